// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite compositor pixel stage.
package sprite_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;

  // RGB565 field MSB positions; the top 4 bits of each field are kept.
  localparam int R_MSB = 15;
  localparam int G_MSB = 10;
  localparam int B_MSB = 4;

  localparam logic [15:0] TRANSPARENT_KEY_DEFAULT = 16'hF81F;
  localparam logic [11:0] DEBUG_COLOR             = 12'h0F0;

  typedef logic [11:0] rgb444_t;

  function automatic rgb444_t rgb565_to_444(input logic [15:0] pix);
    return {pix[R_MSB -: 4], pix[G_MSB -: 4], pix[B_MSB -: 4]};
  endfunction

endpackage

// File: rtl/sprite_compositor_sync_delay.sv
// Parameterised N-stage shift register with a synchronous reset value.
module sync_delay #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [STAGES];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (rst) stage_reg[gi] <= RESET_VAL;
        else     stage_reg[gi] <= d;
      end
    end else begin : g_rest
      always_ff @(posedge clk) begin
        if (rst) stage_reg[gi] <= RESET_VAL;
        else     stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: hit test against the frame-latched position, then colour keying.
// Optional green bounding-box outline when SPRITE_BBOX_DEBUG_EN is defined.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter logic [15:0] TRANSPARENT_KEY = TRANSPARENT_KEY_DEFAULT,
  parameter logic [11:0] BG_COLOR        = 12'h000,
  parameter logic [9:0]  INIT_X          = 10'd320,
  parameter logic [9:0]  INIT_Y          = 10'd240,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  player_x_in,
  input  logic [9:0]  player_y_in,
  input  logic [15:0] sprite_width,
  input  logic [15:0] sprite_height,
  input  logic [15:0] rom_data,
  output logic [9:0]  posx,
  output logic [9:0]  posy,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick
);

  localparam logic SYNC_IDLE   = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic SYNC_ACTIVE = ~SYNC_IDLE;

  // Frame latch
  logic [9:0] posx_reg, posy_reg;
  logic       vsync_prev_reg;
  logic       frame_tick_reg;
  logic       vsync_edge;

  assign vsync_edge = (vsync_in == SYNC_ACTIVE) && (vsync_prev_reg != SYNC_ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      posx_reg       <= INIT_X;
      posy_reg       <= INIT_Y;
      vsync_prev_reg <= SYNC_IDLE;
      frame_tick_reg <= 1'b0;
    end else begin
      vsync_prev_reg <= vsync_in;
      frame_tick_reg <= vsync_edge;
      if (vsync_edge) begin
        posx_reg <= player_x_in;
        posy_reg <= player_y_in;
      end
    end
  end

  assign posx       = posx_reg;
  assign posy       = posy_reg;
  assign frame_tick = frame_tick_reg;

  // Stage 1: hit test in the cycle the ROM is reading the same pixel
  logic [10:0] dx, dy;
  logic        hit_next;
  logic        hit1_reg;
  logic        video_q;

  assign dx = {1'b0, pixel_x} - {1'b0, posx_reg};
  assign dy = {1'b0, pixel_y} - {1'b0, posy_reg};

  // The >= guards stop an underflowed dx/dy from looking like a small offset.
  assign hit_next = (pixel_x >= posx_reg) && (pixel_y >= posy_reg) &&
                    ({5'b0, dx} < sprite_width) && ({5'b0, dy} < sprite_height);

  always_ff @(posedge clk) begin
    if (rst) hit1_reg <= 1'b0;
    else     hit1_reg <= hit_next;
  end

  sync_delay #(
    .WIDTH    (1),
    .STAGES   (1),
    .RESET_VAL(1'b0)
  ) u_video_delay (
    .clk(clk),
    .rst(rst),
    .d  (video_on),
    .q  (video_q)
  );

  sync_delay #(
    .WIDTH    (2),
    .STAGES   (2),
    .RESET_VAL({SYNC_IDLE, SYNC_IDLE})
  ) u_sync_delay (
    .clk(clk),
    .rst(rst),
    .d  ({hsync_in, vsync_in}),
    .q  ({hsync, vsync})
  );

`ifdef SPRITE_BBOX_DEBUG_EN
  logic edge_next;
  logic edge1_reg;

  assign edge_next = (dx == 11'd0) || (dy == 11'd0) ||
                     ({5'b0, dx} == sprite_width - 16'd1) ||
                     ({5'b0, dy} == sprite_height - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) edge1_reg <= 1'b0;
    else     edge1_reg <= edge_next;
  end
`endif

  // Stage 2: colour selection against the ROM pixel for the same position
  rgb444_t rgb_reg, rgb_next;
  logic    opaque;

  assign opaque = hit1_reg && (rom_data != TRANSPARENT_KEY);

  always_comb begin
    rgb_next = BG_COLOR;
    if (!video_q) begin
      rgb_next = '0;
`ifdef SPRITE_BBOX_DEBUG_EN
    end else if (hit1_reg && edge1_reg) begin
      rgb_next = DEBUG_COLOR;
`endif
    end else if (opaque) begin
      rgb_next = rgb565_to_444(rom_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rgb_reg <= '0;
    else     rgb_reg <= rgb_next;
  end

  assign vga_r = rgb_reg[11:8];
  assign vga_g = rgb_reg[7:4];
  assign vga_b = rgb_reg[3:0];

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a scoreboard queue of expected pixel/sync outputs.
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, hsync_in, vsync_in;
  logic [9:0]  player_x_in, player_y_in;
  logic [15:0] sprite_width, sprite_height, rom_data;
  logic [9:0]  posx, posy;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync, frame_tick;

  always #5 clk = ~clk;

  sprite_compositor dut (
    .clk(clk), .rst(rst),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .player_x_in(player_x_in), .player_y_in(player_y_in),
    .sprite_width(sprite_width), .sprite_height(sprite_height), .rom_data(rom_data),
    .posx(posx), .posy(posy), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
  );

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    int          px;
    int          py;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          model_x, model_y;
  logic        model_prev_vs;
  logic        exp_tick;
  logic [15:0] pending_rom;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input int px, input int py, input logic vid,
                                            input logic [15:0] rom);
    int dx, dy, w, h;
    bit hit;
    dx  = px - model_x;
    dy  = py - model_y;
    w   = int'(sprite_width);
    h   = int'(sprite_height);
    hit = (dx >= 0) && (dy >= 0) && (dx < w) && (dy < h);
    if (!vid) return 12'h000;
`ifdef SPRITE_BBOX_DEBUG_EN
    if (hit && (dx == 0 || dy == 0 || dx == w - 1 || dy == h - 1)) return 12'h0F0;
`endif
    if (hit && rom != 16'hF81F) return {rom[15:12], rom[10:7], rom[4:1]};
    return 12'h000;
  endfunction

  // One pixel clock: drive the pixel, feed the ROM word of the previous pixel, check results.
  task automatic step(input int px, input int py, input logic vid, input logic hs,
                      input logic vs, input logic [15:0] rom);
    exp_t e;
    exp_t got;
    pixel_x  = 10'(px);
    pixel_y  = 10'(py);
    video_on = vid;
    hsync_in = hs;
    vsync_in = vs;
    rom_data = pending_rom;
    pending_rom = rom;
    e.rgb = model_rgb(px, py, vid, rom);
    e.hs  = hs;
    e.vs  = vs;
    e.px  = px;
    e.py  = py;
    sb.push_back(e);
    exp_tick = (vs == 1'b0) && (model_prev_vs == 1'b1);
    if (exp_tick) begin
      model_x = int'(player_x_in);
      model_y = int'(player_y_in);
    end
    model_prev_vs = vs;
    @(posedge clk);
    #1;
    chk("frame_tick", 32'(frame_tick), 32'(exp_tick));
    chk("posx", 32'(posx), 32'(model_x));
    chk("posy", 32'(posy), 32'(model_y));
    if (sb.size() >= 2) begin
      got = sb.pop_front();
      chk($sformatf("rgb(%0d,%0d)", got.px, got.py), 32'({vga_r, vga_g, vga_b}), 32'(got.rgb));
      chk("syncs", 32'({hsync, vsync}), 32'({got.hs, got.vs}));
    end
    $display("step px=%0d py=%0d vid=%0b hs=%0b vs=%0b rgb=%h hsync=%0b vsync=%0b posx=%0d tick=%0b",
             px, py, vid, hs, vs, {vga_r, vga_g, vga_b}, hsync, vsync, posx, frame_tick);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
    chk("rst_syncs", 32'({hsync, vsync}), 32'b11);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    chk("rst_posx", 32'(posx), 32'd320);
    chk("rst_posy", 32'(posy), 32'd240);
    rst = 1'b0;
    sb.delete();
    model_x = 320;
    model_y = 240;
    model_prev_vs = 1'b1;
    pending_rom = 16'h0000;
  endtask

  initial begin
    rst = 1'b1;
    pixel_x = '0; pixel_y = '0; video_on = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    player_x_in = 10'd0; player_y_in = 10'd0;
    sprite_width = 16'd16; sprite_height = 16'd16;
    rom_data = 16'h0000;
    pending_rom = 16'h0000;
    do_reset();

    repeat (3) step(0, 0, 1'b0, 1'b1, 1'b1, 16'hFFFF);

    // Requested position ignored until the vsync leading edge
    player_x_in = 10'd100;
    player_y_in = 10'd50;
    repeat (2) step(0, 0, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    step(0, 0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
    step(0, 0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
    step(0, 0, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    player_x_in = 10'd200;
    step(0, 0, 1'b0, 1'b1, 1'b1, 16'hFFFF);

    // Hit boxes, boundaries and colour keying
    step(100, 50, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    step(115, 65, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    step(116, 50, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    step(99,  50, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    step(100, 49, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    step(105, 55, 1'b1, 1'b1, 1'b1, 16'hF81F);
    step(105, 55, 1'b1, 1'b1, 1'b1, 16'hF800);
    step(106, 56, 1'b1, 1'b1, 1'b1, 16'h07E0);
    step(100, 57, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    step(100, 50, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    step(101, 50, 1'b1, 1'b1, 1'b1, 16'h1234);
    sprite_width = 16'd0;
    step(105, 55, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    sprite_width = 16'd16;
    sprite_height = 16'd0;
    step(105, 55, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    sprite_height = 16'd16;
    step(0, 0, 1'b0, 1'b1, 1'b1, 16'hFFFF);

    // Right-edge clipping with no wrap to the next line
    player_x_in = 10'd630;
    step(0, 0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
    step(0, 0, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    for (int x = 625; x <= 639; x++) step(x, 52, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    step(0, 53, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    step(1, 53, 1'b1, 1'b1, 1'b1, 16'hFFFF);

    // Reset mid-line, then pipeline refill at the initial position
    step(631, 55, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    do_reset();
    step(320, 240, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    step(325, 245, 1'b1, 1'b0, 1'b1, 16'hABCD);
    step(319, 240, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    repeat (2) step(0, 0, 1'b0, 1'b1, 1'b1, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
